// File: rtl/sdpram_rr_arbiter_if.sv
// Purpose: client + RAM-side signal bundle for sdpram_rr_arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/addr/data until their grant bit is seen.
// Modports: slave = arbiter side, master = clients plus RAM side.
interface sdpram_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

    // write requesters
    logic [1:0]            wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr0;
    logic [ADDR_WIDTH-1:0] wr_addr1;
    logic [DATA_WIDTH-1:0] wr_data0;
    logic [DATA_WIDTH-1:0] wr_data1;
    logic [1:0]            wr_gnt;
    // read requesters
    logic [1:0]            rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr0;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [1:0]            rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_valid;
    logic                  err_orphan;
    // RAM side
    logic [ADDR_WIDTH-1:0] addra;
    logic                  wena;
    logic [DATA_WIDTH-1:0] dina;
    logic [ADDR_WIDTH-1:0] addrb;
    logic                  renb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  dvalb;

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output wr_gnt,
        input  rd_req, rd_addr0, rd_addr1,
        output rd_gnt, rd_data, rd_valid, err_orphan,
        output addra, wena, dina, addrb, renb,
        input  doutb, dvalb
    );

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  wr_gnt,
        output rd_req, rd_addr0, rd_addr1,
        input  rd_gnt, rd_data, rd_valid, err_orphan,
        input  addra, wena, dina, addrb, renb,
        output doutb, dvalb
    );
endinterface

// File: rtl/sdpram_rr_arbiter.sv
// Purpose: round-robin share of one simple dual-port RAM by 2 writers and 2 readers.
// Latency: grant same cycle; RAM write at N+1; renb at N+1, rd_valid at N+2.
// Backpressure: losers hold req; a read colliding with the granted write waits one cycle.
// Ports: clk, rst (async, active-low), bus (slave modport: requester and RAM signals).
module sdpram_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    sdpram_rr_arbiter_if.slave   bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

    // last-granted requester index; 1 after reset so requester 0 wins the first tie
    logic                  wr_last_q, wr_last_d;
    logic                  rd_last_q, rd_last_d;
    logic                  wena_q, wena_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dina_q, dina_d;
    logic                  renb_q, renb_d;
    logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
    // read tag pipeline: stage 1 lines up with renb, stage 2 with dvalb
    logic                  tag1_vld_q, tag1_vld_d;
    logic                  tag1_id_q, tag1_id_d;
    logic                  tag2_vld_q, tag2_vld_d;
    logic                  tag2_id_q, tag2_id_d;
    logic                  err_orphan_q, err_orphan_d;

    logic [1:0]            wr_gnt;
    logic [1:0]            rd_pick;
    logic [1:0]            rd_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr_w;
    logic [DATA_WIDTH-1:0] wr_data_w;
    logic [ADDR_WIDTH-1:0] rd_addr_w;
    logic                  collision;

    // arbitration
    always_comb begin
        wr_gnt = 2'b00;
        case (bus.wr_req)
            2'b01:   wr_gnt = 2'b01;
            2'b10:   wr_gnt = 2'b10;
            2'b11:   wr_gnt = wr_last_q ? 2'b01 : 2'b10;
            default: wr_gnt = 2'b00;
        endcase

        rd_pick = 2'b00;
        case (bus.rd_req)
            2'b01:   rd_pick = 2'b01;
            2'b10:   rd_pick = 2'b10;
            2'b11:   rd_pick = rd_last_q ? 2'b01 : 2'b10;
            default: rd_pick = 2'b00;
        endcase

        wr_addr_w = wr_gnt[1]  ? bus.wr_addr1 : bus.wr_addr0;
        wr_data_w = wr_gnt[1]  ? bus.wr_data1 : bus.wr_data0;
        rd_addr_w = rd_pick[1] ? bus.rd_addr1 : bus.rd_addr0;

        // Holding the read back one cycle puts it behind the write in the RAM,
        // so it returns the new data without any bypass path.
        collision = (|wr_gnt) && (|rd_pick) && (wr_addr_w == rd_addr_w);
        rd_gnt    = collision ? 2'b00 : rd_pick;
    end

    // next state
    always_comb begin
        wr_last_d    = wr_last_q;
        rd_last_d    = rd_last_q;
        wena_d       = |wr_gnt;
        addra_d      = addra_q;
        dina_d       = dina_q;
        renb_d       = |rd_gnt;
        addrb_d      = addrb_q;
        tag1_vld_d   = |rd_gnt;
        tag1_id_d    = rd_gnt[1];
        tag2_vld_d   = tag1_vld_q;
        tag2_id_d    = tag1_id_q;
        err_orphan_d = err_orphan_q | (bus.dvalb & ~tag2_vld_q);

        if (|wr_gnt) begin
            wr_last_d = wr_gnt[1];
            addra_d   = wr_addr_w;
            dina_d    = wr_data_w;
        end
        if (|rd_gnt) begin
            rd_last_d = rd_gnt[1];
            addrb_d   = rd_addr_w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_last_q    <= 1'b1;
            rd_last_q    <= 1'b1;
            wena_q       <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            renb_q       <= 1'b0;
            addrb_q      <= '0;
            tag1_vld_q   <= 1'b0;
            tag1_id_q    <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_id_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_last_q    <= wr_last_d;
            rd_last_q    <= rd_last_d;
            wena_q       <= wena_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            renb_q       <= renb_d;
            addrb_q      <= addrb_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_id_q    <= tag1_id_d;
            tag2_vld_q   <= tag2_vld_d;
            tag2_id_q    <= tag2_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // outputs; grants are forced low while reset is held
    always_comb begin
        bus.wr_gnt = rst ? wr_gnt : 2'b00;
        bus.rd_gnt = rst ? rd_gnt : 2'b00;
        bus.rd_valid = 2'b00;
        if (bus.dvalb && tag2_vld_q) begin
            bus.rd_valid = tag2_id_q ? 2'b10 : 2'b01;
        end
    end

    assign bus.rd_data    = bus.doutb;
    assign bus.err_orphan = err_orphan_q;
    assign bus.addra      = addra_q;
    assign bus.wena       = wena_q;
    assign bus.dina       = dina_q;
    assign bus.addrb      = addrb_q;
    assign bus.renb       = renb_q;
endmodule

// File: tb/tb_sdpram_rr_arbiter.sv
// Purpose: directed checks of arbitration, routing, collision, orphan and reset behaviour.
// Latency: RAM model answers renb with doutb/dvalb one cycle later.
// Backpressure: requests are held by the stimulus until granted.
module tb_sdpram_rr_arbiter;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    sdpram_rr_arbiter_if #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) bus ();

    sdpram_rr_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model with a side preload port
    logic [31:0] mem [1024];
    logic        ram_dvalb = 1'b0;
    logic [31:0] ram_dout  = 32'h0;
    logic        force_dvalb;
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)   mem[pre_addr] <= pre_data;
        if (bus.wena) mem[bus.addra] <= bus.dina;
        ram_dvalb <= bus.renb;
        if (bus.renb) ram_dout <= mem[bus.addrb];
    end

    assign bus.dvalb = ram_dvalb | force_dvalb;
    assign bus.doutb = ram_dout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        bus.wr_req = 2'b00; bus.rd_req = 2'b00;
        bus.wr_addr0 = '0; bus.wr_addr1 = '0;
        bus.wr_data0 = '0; bus.wr_data1 = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    endtask

    // leaves the bench at a falling edge with reset just released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.wena, bus.renb, bus.err_orphan} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: wena/renb/err_orphan got %b want 000", {bus.wena, bus.renb, bus.err_orphan});
        end
        tests_run++;
        if ({bus.addra, bus.dina, bus.addrb} !== 52'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: addra %h dina %h addrb %h want all 0", bus.addra, bus.dina, bus.addrb);
        end
        tests_run++;
        if ({bus.wr_gnt, bus.rd_gnt, bus.rd_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_gnt: wr_gnt %b rd_gnt %b rd_valid %b want 0", bus.wr_gnt, bus.rd_gnt, bus.rd_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.wr_req = 2'b01; bus.wr_addr0 = 10'h001; bus.wr_data0 = 32'h55;
        #1;
        tests_run++;
        if (bus.wr_gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL first_wr_gnt: got %b want 01", bus.wr_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.wena !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_wena: got %b want 1", bus.wena);
        end
        tests_run++;
        if (bus.addra !== 10'h001) begin
            tests_failed++;
            $display("FAIL first_addra: got %h want 001", bus.addra);
        end
        tests_run++;
        if (bus.dina !== 32'h55) begin
            tests_failed++;
            $display("FAIL first_dina: got %h want 55", bus.dina);
        end
        @(negedge clk);
        bus.wr_req = 2'b00;
    endtask

    task automatic test_write_rr();
        logic [1:0]  exp_g [4];
        logic [31:0] exp_d [4];
        logic [9:0]  exp_a [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'hA0, 32'hB1, 32'hA0, 32'hB1};
        exp_a = '{10'h003, 10'h004, 10'h003, 10'h004};
        do_reset();
        bus.wr_req = 2'b11;
        bus.wr_addr0 = 10'h003; bus.wr_data0 = 32'hA0;
        bus.wr_addr1 = 10'h004; bus.wr_data1 = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (bus.wr_gnt !== exp_g[i]) begin
                tests_failed++;
                $display("FAIL wr_rr_gnt[%0d]: got %b want %b", i, bus.wr_gnt, exp_g[i]);
            end
            @(posedge clk); #1;
            tests_run++;
            if (bus.dina !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL wr_rr_dina[%0d]: got %h want %h", i, bus.dina, exp_d[i]);
            end
            tests_run++;
            if (bus.addra !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL wr_rr_addra[%0d]: got %h want %h", i, bus.addra, exp_a[i]);
            end
            @(negedge clk);
        end
        bus.wr_req = 2'b00;
    endtask

    task automatic test_read_routing();
        do_reset();
        preload(10'h001, 32'hA);
        preload(10'h002, 32'hB);
        bus.rd_req = 2'b11; bus.rd_addr0 = 10'h001; bus.rd_addr1 = 10'h002;
        #1;
        tests_run++;
        if (bus.rd_gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rd_gnt_first: got %b want 01", bus.rd_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.renb, bus.addrb} !== {1'b1, 10'h001}) begin
            tests_failed++;
            $display("FAIL rd_issue0: renb %b addrb %h want 1/001", bus.renb, bus.addrb);
        end
        @(negedge clk); #1;
        tests_run++;
        if (bus.rd_gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd_gnt_second: got %b want 10", bus.rd_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.renb, bus.addrb} !== {1'b1, 10'h002}) begin
            tests_failed++;
            $display("FAIL rd_issue1: renb %b addrb %h want 1/002", bus.renb, bus.addrb);
        end
        @(negedge clk);
        bus.rd_req = 2'b00;
        #1;
        tests_run++;
        if ({bus.rd_valid, bus.rd_data} !== {2'b01, 32'hA}) begin
            tests_failed++;
            $display("FAIL rd_resp0: rd_valid %b rd_data %h want 01/0000000a", bus.rd_valid, bus.rd_data);
        end
        @(negedge clk); #1;
        tests_run++;
        if ({bus.rd_valid, bus.rd_data} !== {2'b10, 32'hB}) begin
            tests_failed++;
            $display("FAIL rd_resp1: rd_valid %b rd_data %h want 10/0000000b", bus.rd_valid, bus.rd_data);
        end
        @(negedge clk); #1;
        tests_run++;
        if (bus.rd_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_idle: rd_valid %b want 00", bus.rd_valid);
        end
    endtask

    task automatic test_collision();
        do_reset();
        preload(10'h010, 32'hDEAD);
        bus.wr_req = 2'b01; bus.wr_addr0 = 10'h010; bus.wr_data0 = 32'h77;
        bus.rd_req = 2'b10; bus.rd_addr1 = 10'h010;
        #1;
        tests_run++;
        if ({bus.wr_gnt, bus.rd_gnt} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL coll_gnt: wr_gnt %b rd_gnt %b want 01/00", bus.wr_gnt, bus.rd_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.wena, bus.renb} !== 2'b10) begin
            tests_failed++;
            $display("FAIL coll_issue_w: wena %b renb %b want 1/0", bus.wena, bus.renb);
        end
        @(negedge clk);
        bus.wr_req = 2'b00;
        #1;
        tests_run++;
        if (bus.rd_gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL coll_regrant: rd_gnt %b want 10", bus.rd_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.wena, bus.renb, bus.addrb} !== {1'b0, 1'b1, 10'h010}) begin
            tests_failed++;
            $display("FAIL coll_issue_r: wena %b renb %b addrb %h want 0/1/010", bus.wena, bus.renb, bus.addrb);
        end
        @(negedge clk);
        bus.rd_req = 2'b00;
        @(negedge clk); #1;
        tests_run++;
        if ({bus.rd_valid, bus.rd_data} !== {2'b10, 32'h77}) begin
            tests_failed++;
            $display("FAIL coll_resp: rd_valid %b rd_data %h want 10/00000077", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        force_dvalb = 1'b1;
        #1;
        tests_run++;
        if (bus.rd_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL orphan_rd_valid: got %b want 00", bus.rd_valid);
        end
        @(posedge clk); #1;
        force_dvalb = 1'b0;
        tests_run++;
        if (bus.err_orphan !== 1'b1) begin
            tests_failed++;
            $display("FAIL orphan_set: err_orphan %b want 1", bus.err_orphan);
        end
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (bus.err_orphan !== 1'b1) begin
            tests_failed++;
            $display("FAIL orphan_sticky: err_orphan %b want 1", bus.err_orphan);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.err_orphan !== 1'b0) begin
            tests_failed++;
            $display("FAIL orphan_clear: err_orphan %b want 0", bus.err_orphan);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        // move both pointers to requester 0
        bus.wr_req = 2'b01; bus.wr_addr0 = 10'h020; bus.wr_data0 = 32'h1;
        bus.rd_req = 2'b01; bus.rd_addr0 = 10'h030;
        @(negedge clk);
        clear_inputs();
        // renb is high now; the RAM answers at the coming edge
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bus.rd_valid, bus.renb, bus.err_orphan} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_flush: rd_valid %b renb %b err_orphan %b want 00/0/0", bus.rd_valid, bus.renb, bus.err_orphan);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.rd_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL midrst_late_dval: rd_valid %b want 00", bus.rd_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.err_orphan !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_orphan: err_orphan %b want 1", bus.err_orphan);
        end
        @(negedge clk);
        bus.wr_req = 2'b11; bus.wr_addr0 = 10'h040; bus.wr_addr1 = 10'h041;
        bus.rd_req = 2'b11; bus.rd_addr0 = 10'h050; bus.rd_addr1 = 10'h051;
        #1;
        tests_run++;
        if ({bus.wr_gnt, bus.rd_gnt} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL midrst_tie: wr_gnt %b rd_gnt %b want 01/01", bus.wr_gnt, bus.rd_gnt);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        force_dvalb  = 1'b0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;
        test_reset();
        test_write_rr();
        test_read_routing();
        test_collision();
        test_orphan();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sdpram_rr_arbiter.md
# sdpram_rr_arbiter

Round-robin arbiter and sequencer that shares one simple dual-port RAM between two write requesters and two read requesters. Port A (write) and port B (read) are arbitrated independently. Each read response is routed back to the requester that issued it, and a same-cycle read/write address collision is resolved so the read always returns the newly written data. The block sits between the client logic and the `sdp_s` side of the RAM, and drives the RAM through the `sdp_m` signal set.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width.
- MEM_DEPTH, 1024, RAM words; ADDR_WIDTH = $clog2(MEM_DEPTH) (localparam).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- wr_req  in  2  write request per requester; held with address and data until granted.
- wr_addr0, wr_addr1  in  ADDR_WIDTH  write address per requester.
- wr_data0, wr_data1  in  DATA_WIDTH  write data per requester.
- wr_gnt  out  2  one-hot write grant (combinational).
- rd_req  in  2  read request per requester; held with address until granted.
- rd_addr0, rd_addr1  in  ADDR_WIDTH  read address per requester.
- rd_gnt  out  2  one-hot read grant (combinational).
- rd_data  out  DATA_WIDTH  = doutb (pass-through).
- rd_valid  out  2  read response valid, routed to the issuing requester.
- err_orphan  out  1  sticky; set on dvalb with no outstanding read.
- addra  out  ADDR_WIDTH  RAM write address.
- wena  out  1  RAM write enable.
- dina  out  DATA_WIDTH  RAM write data.
- addrb  out  ADDR_WIDTH  RAM read address.
- renb  out  1  RAM read enable.
- doutb  in  DATA_WIDTH  RAM read data.
- dvalb  in  1  RAM read data valid, expected exactly 1 cycle after renb.

## Operation
- **Write arbiter:**
  - Each cycle with wr_req != 0, grant exactly one requester.
  - Single request: grant it.
  - Both requesting: grant the requester not granted last; pointer wr_last updates only on a grant.
- **Read arbiter:** same round-robin scheme with its own pointer, rd_last.
- **Write issue:** a grant in cycle N registers wena=1 and addra/dina from the winner for cycle N+1. With no grant, wena=0 in N+1; addra/dina hold their last values.
- **Read issue:** a grant in cycle N registers renb=1 and addrb in N+1. A 2-stage tag pipeline {valid, id} records the winner.
- **Response routing:**
  - When dvalb=1 and stage-2 tag is valid: rd_valid[id]=1, other bit 0.
  - When dvalb=1 and the tag is invalid: rd_valid=0 and err_orphan is set. err_orphan clears only on reset.
- **Collision rule:** if, in the same cycle, the read winner's address equals the write winner's address, withhold rd_gnt that cycle.
  - rd_last does not change.
  - Re-arbitrate the read next cycle, so the read reaches the RAM one cycle after the write.
- Read and write to different addresses proceed in the same cycle.
- Arbitration is not blocked by outstanding reads; throughput is one write plus one read per cycle.

## Timing
- **Reset values (rst=0):**
  - wena=0, renb=0, addra=0, dina=0, addrb=0.
  - wr_gnt=0, rd_gnt=0, rd_valid=0, err_orphan=0.
  - Tag pipeline cleared; wr_last=rd_last=1, so requester 0 wins the first tie.
- Reset asserted mid-operation discards in-flight tags. A dvalb arriving after reset release therefore flags err_orphan.
- Grant is in the same cycle as the request when it wins. A losing requester keeps wr_req/rd_req high; the inputs are sampled only on grant.
- Write latency: grant at N, RAM write at N+1.
- Read latency: grant at N, renb at N+1, dvalb/rd_valid at N+2. rd_valid is combinational from dvalb.
- A requester deasserting req in the grant cycle's next edge is legal; a grant is never issued without req.

## Test plan
- **Reset:** hold rst=0 for 3 cycles -> all outputs 0. Release; single wr_req[0], addr 0x01, data 0x55 -> wr_gnt=01 same cycle; wena=1, addra=0x01, dina=0x55 next cycle.
- **Write round-robin:** wr_req=11 held for 4 cycles -> wr_gnt sequence 01,10,01,10; dina alternates wr_data0/wr_data1.
- **Read routing:** rd_req=11, addrs 0x01/0x02, RAM model with 1-cycle latency preloaded 0xA/0xB -> rd_valid=01 with rd_data=0xA at N+2, then rd_valid=10 with rd_data=0xB at N+3.
- **Collision:** wr_req[0] to 0x10 with data 0x77 and rd_req[1] to 0x10 in the same cycle -> rd_gnt=0 that cycle and granted the next. renb follows wena by 1 cycle; rd_valid=10 with rd_data=0x77.
- **Orphan:** force dvalb=1 with no prior read -> rd_valid=00 and err_orphan=1, held until rst=0.
- **Reset mid-read:** assert rst between renb and dvalb -> rd_valid stays 0, tags cleared, wr_last/rd_last restored so the first tie after release grants requester 0.
